// File: rtl/uart8_pkg.sv
// uart8_pkg: shared FSM state encoding, data width and baud divider helpers.
package uart8_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // Clocks per TX bit; never below one so the divider stays meaningful.
  function automatic int unsigned tx_div(input int unsigned clock_rate,
                                         input int unsigned baud_rate);
    int unsigned d;
    d = clock_rate / baud_rate;
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  // Clocks per RX oversampling tick.
  function automatic int unsigned rx_div(input int unsigned clock_rate,
                                         input int unsigned baud_rate,
                                         input int unsigned oversample);
    int unsigned d;
    d = clock_rate / (baud_rate * oversample);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart8_baud_gen.sv
// uart8_baud_gen: free-running divider, held at zero by clear_i, with a
// registered one-clk tick every DIV clks after clear is released.
module uart8_baud_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || (cnt_q == CW'(DIV - 1))) cnt_d = '0;
  end

  // Tick is registered from the next count so it lines up with cnt_q == DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= !clear_i && (cnt_d == CW'(DIV - 1));
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart8.sv
// uart8: full-duplex 8N1 UART, independent TX and oversampling RX engines.
// Build option: define UART8_RX_SYNC_EN to add a 2-flop synchronizer on rxIn.
module uart8
  import uart8_pkg::*;
#(
  parameter int unsigned CLOCK_RATE         = 12000000,
  parameter int unsigned BAUD_RATE          = 9600,
  parameter int unsigned RX_OVERSAMPLE_RATE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxEn,
  input  logic              rxIn,
  output logic              rxBusy,
  output logic              rxDone,
  output logic              rxErr,
  output logic [DATA_W-1:0] rxOut,
  input  logic              txEn,
  input  logic              txStart,
  input  logic [DATA_W-1:0] txIn,
  output logic              txBusy,
  output logic              txDone,
  output logic              txOut
);

  localparam int unsigned TX_DIV = tx_div(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned RX_DIV = rx_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE_RATE);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned TCNT_W = $clog2(RX_OVERSAMPLE_RATE);
  localparam int unsigned HALF   = RX_OVERSAMPLE_RATE / 2;

  logic rx_s;

`ifdef UART8_RX_SYNC_EN
  logic sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxIn;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;
`else
  assign rx_s = rxIn;
`endif

  // ---------------- transmitter ----------------
  state_t            tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_idle, tx_tick;

  assign tx_idle = (tx_state_q == ST_IDLE);

  uart8_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
    .clk    (clk),
    .rst    (reset),
    .clear_i(tx_idle),
    .tick_o (tx_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_shreg_q <= '0;
      tx_bit_q   <= '0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shreg_q <= tx_shreg_d;
      tx_bit_q   <= tx_bit_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // START emits bit 0 on its closing tick; DATA then walks bits 1..7 and the stop bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shreg_d = tx_shreg_q;
    tx_bit_d   = tx_bit_q;
    tx_out_d   = tx_out_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    if (!tx_idle && !txEn) begin
      tx_state_d = ST_IDLE;
      tx_out_d   = 1'b1;
      tx_busy_d  = 1'b0;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          tx_out_d = 1'b1;
          if (txEn && txStart) begin
            tx_shreg_d = txIn;
            tx_busy_d  = 1'b1;
            tx_out_d   = 1'b0;
            tx_state_d = ST_START;
          end
        end
        ST_START: if (tx_tick) begin
          tx_out_d   = tx_shreg_q[0];
          tx_shreg_d = tx_shreg_q >> 1;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end
        ST_DATA: if (tx_tick) begin
          if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
            tx_out_d   = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_out_d   = tx_shreg_q[0];
            tx_shreg_d = tx_shreg_q >> 1;
            tx_bit_d   = tx_bit_q + BIT_W'(1);
          end
        end
        ST_STOP: if (tx_tick) begin
          tx_done_d  = 1'b1;
          tx_busy_d  = 1'b0;
          tx_state_d = ST_IDLE;
        end
        default: tx_state_d = ST_IDLE;
      endcase
    end
  end

  assign txOut  = tx_out_q;
  assign txBusy = tx_busy_q;
  assign txDone = tx_done_q;

  // ---------------- receiver ----------------
  state_t            rx_state_q, rx_state_d;
  logic [DATA_W-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_W-1:0] rx_out_q, rx_out_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [TCNT_W-1:0] rx_tcnt_q, rx_tcnt_d;
  logic              rx_busy_q, rx_busy_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_err_q, rx_err_d;
  logic              rx_prev_q;
  logic              rx_idle, rx_tick, rx_fall;

  assign rx_idle = (rx_state_q == ST_IDLE);
  assign rx_fall = rx_prev_q & ~rx_s;

  uart8_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
    .clk    (clk),
    .rst    (reset),
    .clear_i(rx_idle),
    .tick_o (rx_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= ST_IDLE;
      rx_shreg_q <= '0;
      rx_out_q   <= '0;
      rx_bit_q   <= '0;
      rx_tcnt_q  <= '0;
      rx_busy_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shreg_q <= rx_shreg_d;
      rx_out_q   <= rx_out_d;
      rx_bit_q   <= rx_bit_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_busy_q  <= rx_busy_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
      rx_prev_q  <= rx_s;
    end
  end

  // Frame completes at the mid-stop sample so the next start edge is never missed.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shreg_d = rx_shreg_q;
    rx_out_d   = rx_out_q;
    rx_bit_d   = rx_bit_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_busy_d  = rx_busy_q;
    rx_err_d   = rx_err_q;
    rx_done_d  = 1'b0;
    if (!rx_idle && !rxEn) begin
      rx_state_d = ST_IDLE;
      rx_busy_d  = 1'b0;
    end else begin
      case (rx_state_q)
        ST_IDLE: if (rxEn && rx_fall) begin
          rx_busy_d  = 1'b1;
          rx_err_d   = 1'b0;
          rx_tcnt_d  = '0;
          rx_state_d = ST_START;
        end
        ST_START: if (rx_tick) begin
          if (rx_tcnt_q == TCNT_W'(HALF - 1)) begin
            rx_tcnt_d = '0;
            rx_bit_d  = '0;
            if (rx_s) begin
              rx_busy_d  = 1'b0;
              rx_state_d = ST_IDLE;
            end else begin
              rx_state_d = ST_DATA;
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
          end
        end
        ST_DATA: if (rx_tick) begin
          if (rx_tcnt_q == TCNT_W'(RX_OVERSAMPLE_RATE - 1)) begin
            rx_tcnt_d  = '0;
            rx_shreg_d = {rx_s, rx_shreg_q[DATA_W-1:1]};
            if (rx_bit_q == BIT_W'(DATA_W - 1)) rx_state_d = ST_STOP;
            else                                 rx_bit_d   = rx_bit_q + BIT_W'(1);
          end else begin
            rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
          end
        end
        ST_STOP: if (rx_tick) begin
          if (rx_tcnt_q == TCNT_W'(RX_OVERSAMPLE_RATE - 1)) begin
            rx_err_d   = !rx_s;
            rx_out_d   = rx_shreg_q;
            rx_done_d  = 1'b1;
            rx_busy_d  = 1'b0;
            rx_state_d = ST_IDLE;
          end else begin
            rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
          end
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  assign rxOut  = rx_out_q;
  assign rxBusy = rx_busy_q;
  assign rxDone = rx_done_q;
  assign rxErr  = rx_err_q;

endmodule

// File: tb/tb_uart8.sv
// tb_uart8: self-checking bench for uart8 at 12 MHz / 9600 baud / 13x oversampling.
module tb_uart8;

  localparam int unsigned CLK_HZ   = 12000000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned OSR      = 13;
  localparam int unsigned BIT_CLKS = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       reset, rxEn, txEn, txStart;
  logic [7:0] txIn;
  logic       txOut, txBusy, txDone, rxBusy, rxDone, rxErr;
  logic [7:0] rxOut;
  logic       loop_en, drv_rx, rx_line;

  assign rx_line = loop_en ? txOut : drv_rx;

  always #5 clk = ~clk;

  uart8 #(
    .CLOCK_RATE        (CLK_HZ),
    .BAUD_RATE         (BAUD),
    .RX_OVERSAMPLE_RATE(OSR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rxEn   (rxEn),
    .rxIn   (rx_line),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .rxOut  (rxOut),
    .txEn   (txEn),
    .txStart(txStart),
    .txIn   (txIn),
    .txBusy (txBusy),
    .txDone (txDone),
    .txOut  (txOut)
  );

  // Passive monitors: pulse counts, received bytes and txBusy run lengths.
  int         tx_done_n = 0;
  int         rx_busy_n = 0;
  int         busy_run  = 0;
  int         busy_runs[$];
  logic [8:0] rx_q[$];

  always @(negedge clk) begin
    if (txDone) tx_done_n <= tx_done_n + 1;
    if (rxBusy) rx_busy_n <= rx_busy_n + 1;
    if (rxDone) rx_q.push_back({rxErr, rxOut});
    if (txBusy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      busy_runs.push_back(busy_run);
      busy_run <= 0;
    end
  end

  function automatic logic [8:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
  endfunction

  function automatic int run_at(input int i);
    return (i < busy_runs.size()) ? busy_runs[i] : -1;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tx_fall(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * BIT_CLKS; i++) begin
      @(negedge clk);
      if (txOut === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_start_seen"}, 32'(ok), 32'd1);
  endtask

  // Expected line: index k is what the wire carries during bit period k.
  task automatic check_tx_bits(input string name, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    repeat (BIT_CLKS / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) repeat (BIT_CLKS) @(negedge clk);
      check($sformatf("%s_bit%0d", name, k), 32'(txOut), 32'(frame[k]));
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      drv_rx = frame[k];
      repeat (BIT_CLKS) @(negedge clk);
    end
    drv_rx = 1'b1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_txOut"},  32'(txOut),  32'd1);
    check({name, "_txBusy"}, 32'(txBusy), 32'd0);
    check({name, "_txDone"}, 32'(txDone), 32'd0);
    check({name, "_rxBusy"}, 32'(rxBusy), 32'd0);
    check({name, "_rxDone"}, 32'(rxDone), 32'd0);
    check({name, "_rxErr"},  32'(rxErr),  32'd0);
    check({name, "_rxOut"},  32'(rxOut),  32'h00);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_out;
    logic       exp_err;
  } rx_vec_t;

  rx_vec_t    rx_tab[3];
  logic [7:0] exp_rx[$];
  logic [7:0] b0, b1;
  int         d_tx, n_rx, n_run, n_rb;
  bit         ok;

  initial begin
    rx_tab[0] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
    rx_tab[1] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    rx_tab[2] = '{8'hC3, 1'b1, 8'hC3, 1'b0};

    reset = 1'b1; rxEn = 1'b0; txEn = 1'b0; txStart = 1'b0; txIn = 8'h00;
    loop_en = 1'b1; drv_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0; rxEn = 1'b1; txEn = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback of one byte with txStart held shorter than a frame.
    d_tx = tx_done_n; n_rx = rx_q.size(); n_run = busy_runs.size();
    txIn = 8'b10001010; txStart = 1'b1;
    fork
      begin
        repeat (5500) @(negedge clk);
        txStart = 1'b0;
      end
      begin
        wait_tx_fall("lb", ok);
        check_tx_bits("lb", 8'b10001010);
      end
    join
    repeat (1000) @(negedge clk);
    check("lb_txdone_cnt", 32'(tx_done_n - d_tx), 32'd1);
    check("lb_busy_runs", 32'(busy_runs.size() - n_run), 32'd1);
    check("lb_busy_len", 32'(run_at(n_run)), 32'(10 * BIT_CLKS));
    check("lb_rx_cnt", 32'(rx_q.size() - n_rx), 32'd1);
    check("lb_rx_data", 32'(rx_at(n_rx)), {23'd0, 1'b0, 8'b10001010});
    check("lb_idle_txBusy", 32'(txBusy), 32'd0);

    // Directly driven frames, including bad stop bits.
    loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_rx = rx_q.size();
      drive_rx_frame(rx_tab[i].data, rx_tab[i].stop);
      repeat (50) @(negedge clk);
      check($sformatf("fe%0d_cnt", i), 32'(rx_q.size() - n_rx), 32'd1);
      check($sformatf("fe%0d_out", i), 32'(rx_at(n_rx)), {23'd0, rx_tab[i].exp_err, rx_tab[i].exp_out});
      check($sformatf("fe%0d_err_held", i), 32'(rxErr), 32'(rx_tab[i].exp_err));
      check($sformatf("fe%0d_busy", i), 32'(rxBusy), 32'd0);
    end

    // Start glitch shorter than half a bit.
    n_rx = rx_q.size();
    drv_rx = 1'b0;
    repeat (100) @(negedge clk);
    check("gl_busy_hi", 32'(rxBusy), 32'd1);
    repeat (200) @(negedge clk);
    drv_rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("gl_busy_lo", 32'(rxBusy), 32'd0);
    check("gl_no_done", 32'(rx_q.size() - n_rx), 32'd0);

    // TX abort via txEn while RX is disabled on the looped line.
    loop_en = 1'b1; rxEn = 1'b0;
    d_tx = tx_done_n; n_rx = rx_q.size(); n_rb = rx_busy_n;
    txIn = 8'($urandom); txStart = 1'b1;
    wait_tx_fall("ab", ok);
    txStart = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    txEn = 1'b0;
    @(negedge clk);
    check("ab_txOut", 32'(txOut), 32'd1);
    check("ab_txBusy", 32'(txBusy), 32'd0);
    repeat (1000) @(negedge clk);
    check("ab_no_txdone", 32'(tx_done_n - d_tx), 32'd0);
    check("ab_rx_ignored", 32'(rx_busy_n - n_rb), 32'd0);
    check("ab_rx_no_done", 32'(rx_q.size() - n_rx), 32'd0);
    txEn = 1'b1; rxEn = 1'b1;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a looped frame.
    txIn = 8'h00; txStart = 1'b1;
    wait_tx_fall("rm", ok);
    txStart = 1'b0;
    repeat (5 * BIT_CLKS) @(negedge clk);
    check("rm_pre_txBusy", 32'(txBusy), 32'd1);
    check("rm_pre_rxBusy", 32'(rxBusy), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rm");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back random bytes with txStart held across both frames.
    b0 = 8'($urandom); b1 = 8'($urandom);
    exp_rx.delete();
    exp_rx.push_back(b0);
    exp_rx.push_back(b1);
    d_tx = tx_done_n; n_rx = rx_q.size(); n_run = busy_runs.size();
    txIn = b0; txStart = 1'b1;
    wait_tx_fall("bb0", ok);
    txIn = b1;
    check_tx_bits("bb0", b0);
    wait_tx_fall("bb1", ok);
    txStart = 1'b0;
    check_tx_bits("bb1", b1);
    repeat (1500) @(negedge clk);
    check("bb_txdone_cnt", 32'(tx_done_n - d_tx), 32'd2);
    check("bb_busy_runs", 32'(busy_runs.size() - n_run), 32'd2);
    check("bb_busy_len0", 32'(run_at(n_run)), 32'(10 * BIT_CLKS));
    check("bb_busy_len1", 32'(run_at(n_run + 1)), 32'(10 * BIT_CLKS));
    check("bb_rx_cnt", 32'(rx_q.size() - n_rx), 32'd2);
    for (int i = 0; i < 2; i++)
      check($sformatf("bb_rx%0d", i), 32'(rx_at(n_rx + i)), {23'd0, 1'b0, exp_rx[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (120000) @(negedge clk);
    $display("FAIL watchdog: bench still running after 120000 clks");
    $fatal(1);
  end

endmodule
